// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: one launch per frame, a fixed idle gap
// after each done, and a watchdog that recovers from a transmitter that never finishes.
module uart_tx_fifo #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int FREQUENCY  = 87,
  parameter int GAP_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_Wr_En,
  input  logic [7:0]        i_Wr_Byte,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done,
  output logic              o_Busy,
  output logic              o_Timeout
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int WD_W  = $clog2(12 * FREQUENCY);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(12 * FREQUENCY - 1);
  localparam logic [7:0]      GAP_LAST = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  logic [7:0]        mem_q [DEPTH];
  state_e            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [7:0]        gap_q, gap_d;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, empty_q, ovf_q, dv_q, busy_q, timeout_q;
  logic [7:0]        byte_q, byte_d;
  logic              dv_d, timeout_d;
  logic              wr_accept, launch_ok, pop;

  // The full check uses the registered flag, so a write racing a pop into a full FIFO is dropped.
  assign wr_accept = i_Wr_En && !full_q;
  assign launch_ok = !empty_q && !i_Tx_Active;

  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    gap_d     = gap_q;
    pop       = 1'b0;
    dv_d      = 1'b0;
    byte_d    = byte_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (launch_ok) begin
          pop     = 1'b1;
          dv_d    = 1'b1;
          byte_d  = mem_q[rd_ptr_q];
          wd_d    = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (i_Tx_Done) begin
          gap_d   = '0;
          state_d = ST_GAP;
        end else if (wd_q == WD_LAST) begin
          timeout_d = 1'b1;
          gap_d     = '0;
          state_d   = ST_GAP;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_GAP: begin
        // The last gap clock also makes the idle decision, so a queued byte
        // launches after exactly GAP_CYCLES idle clocks following done.
        if (gap_q == GAP_LAST) begin
          if (launch_ok) begin
            pop     = 1'b1;
            dv_d    = 1'b1;
            byte_d  = mem_q[rd_ptr_q];
            wd_d    = '0;
            state_d = ST_SEND;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    count_d = count_q;
    if (wr_accept && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!wr_accept && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= i_Wr_Byte;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wd_q      <= '0;
      gap_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      ovf_q     <= 1'b0;
      dv_q      <= 1'b0;
      byte_q    <= 8'h00;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wd_q      <= wd_d;
      gap_q     <= gap_d;
      count_q   <= count_d;
      full_q    <= (count_d == CNT_W'(DEPTH));
      empty_q   <= (count_d == '0);
      ovf_q     <= i_Wr_En && full_q;
      dv_q      <= dv_d;
      byte_q    <= byte_d;
      busy_q    <= (state_d != ST_IDLE) || (count_d != '0);
      timeout_q <= timeout_d;
      if (wr_accept) begin
        wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      end
    end
  end

  assign o_Full     = full_q;
  assign o_Empty    = empty_q;
  assign o_Count    = count_q;
  assign o_Overflow = ovf_q;
  assign o_Tx_DV    = dv_q;
  assign o_Tx_Byte  = byte_q;
  assign o_Busy     = busy_q;
  assign o_Timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a transmitter stub answers launches; launched bytes are
// checked against a queue of accepted writes, with occupancy/flag tracking each cycle.
module tb_uart_tx_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int FREQ   = 87;
  localparam int GAP    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_Wr_En = 1'b0;
  logic [7:0]        i_Wr_Byte = 8'h00;
  logic              o_Full, o_Empty, o_Overflow, o_Tx_DV, o_Busy, o_Timeout;
  logic [ADDR_W:0]   o_Count;
  logic [7:0]        o_Tx_Byte;
  logic              i_Tx_Active, i_Tx_Done;

  uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .FREQUENCY(FREQ), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .i_Wr_En(i_Wr_En), .i_Wr_Byte(i_Wr_Byte),
    .o_Full(o_Full), .o_Empty(o_Empty), .o_Count(o_Count), .o_Overflow(o_Overflow),
    .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte), .i_Tx_Active(i_Tx_Active),
    .i_Tx_Done(i_Tx_Done), .o_Busy(o_Busy), .o_Timeout(o_Timeout)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int  tests_run = 0;
  int  errors = 0;
  int  exp_cnt = 0;
  bit  ovf_exp = 0;
  bit  to_expect = 0;
  bit  mon_en = 0;
  bit  gap_check = 0;
  bit  prev_dv = 0, prev_busy = 0;
  int  launches = 0, timeouts = 0, peak = 0;
  int  last_dv_cyc = 0, done_cyc = 0, busy_fall_cyc = 0, wr_cyc = 0;
  bit  done_valid = 0;

  // transmitter stub
  int   frame_len = 20;
  int   stub_cnt = 0;
  logic stub_active = 1'b0;
  logic stub_done = 1'b0;
  logic hold_active = 1'b0;
  assign i_Tx_Active = stub_active | hold_active;
  assign i_Tx_Done   = stub_done;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // ---------------- monitor + transmitter stub ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_Tx_DV) begin
        check_eq("dv_width", prev_dv, 0);
        launches++;
        last_dv_cyc = cyc;
        if (exp_cnt > 0) exp_cnt--;
        if (exp_q.size() == 0) check_eq("dv_unexpected", 1, 0);
        else check_eq("tx_byte", o_Tx_Byte, exp_q.pop_front());
        if (gap_check && done_valid) check_eq("gap_latency", cyc - done_cyc, GAP + 1);
        done_valid = 0;
      end
      check_eq("count", o_Count, exp_cnt);
      check_eq("empty", o_Empty, exp_cnt == 0);
      check_eq("full", o_Full, exp_cnt == DEPTH);
      check_eq("overflow", o_Overflow, ovf_exp);
      ovf_exp = 0;
      if (o_Timeout) begin
        timeouts++;
        check_eq("timeout_expected", to_expect, 1);
        check_eq("timeout_latency", cyc - last_dv_cyc, 12 * FREQ);
      end
      if (o_Count > peak) peak = o_Count;
      if (prev_busy && !o_Busy) busy_fall_cyc = cyc;
      prev_dv = o_Tx_DV;
      prev_busy = o_Busy;
    end
    stub_done = 1'b0;
    if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        stub_done = 1'b1;
        stub_active = 1'b0;
        done_cyc = cyc;
        done_valid = 1;
      end
    end
    if (o_Tx_DV && frame_len > 0) begin
      stub_cnt = frame_len;
      stub_active = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic write_byte(input logic [7:0] b);
    @(negedge clk); #1;
    i_Wr_En = 1'b1;
    i_Wr_Byte = b;
    wr_cyc = cyc;
    if (exp_cnt < DEPTH) begin
      exp_q.push_back(b);
      exp_cnt++;
    end else begin
      ovf_exp = 1;
    end
  endtask

  task automatic end_writes();
    @(negedge clk); #1;
    i_Wr_En = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); #1;
    rst = 1'b1;
    i_Wr_En = 1'b0;
    exp_q.delete();
    exp_cnt = 0;
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && !o_Busy && stub_cnt == 0) && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    check_eq(tag, n < budget, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #2;
    mon_en = 1;
    check_eq("rst_empty", o_Empty, 1);
    check_eq("rst_full", o_Full, 0);
    check_eq("rst_count", o_Count, 0);
    check_eq("rst_dv", o_Tx_DV, 0);
    check_eq("rst_byte", o_Tx_Byte, 8'h00);
    check_eq("rst_busy", o_Busy, 0);
    check_eq("rst_ovf", o_Overflow, 0);
    check_eq("rst_timeout", o_Timeout, 0);

    // single byte and launch latency
    frame_len = 20;
    base = launches;
    write_byte(8'hA5);
    end_writes();
    wait_drain("single_drain", 200);
    check_eq("single_launches", launches - base, 1);
    check_eq("single_latency", last_dv_cyc - wr_cyc, 2);

    // burst of four, gap timing, busy fall
    idle(3);
    peak = 0;
    done_valid = 0;
    gap_check = 1;
    base = launches;
    for (int i = 1; i <= 4; i++) write_byte(8'(i));
    end_writes();
    wait_drain("burst_drain", 400);
    gap_check = 0;
    check_eq("burst_peak", peak, 3);
    check_eq("burst_launches", launches - base, 4);
    check_eq("burst_busy_fall", busy_fall_cyc - done_cyc, GAP + 1);

    // fill with transmitter held, overflow, then write racing the first launch
    idle(3);
    frame_len = 5;
    hold_active = 1'b1;
    base = launches;
    for (int i = 0; i < DEPTH + 1; i++) write_byte(8'h10 + 8'(i));
    end_writes();
    check_eq("fill_full", o_Full, 1);
    check_eq("fill_count", o_Count, DEPTH);
    idle(2);
    write_byte(8'hEE);
    hold_active = 1'b0;
    end_writes();
    check_eq("race_count", o_Count, DEPTH - 1);
    wait_drain("fill_drain", 600);
    check_eq("fill_launches", launches - base, DEPTH);

    // transmitter that never finishes
    idle(3);
    frame_len = 0;
    to_expect = 1;
    base = timeouts;
    write_byte(8'hC3);
    write_byte(8'h3C);
    end_writes();
    wait_drain("timeout_drain", 3000);
    check_eq("timeout_count", timeouts - base, 2);
    to_expect = 0;

    // reset during SEND with five bytes queued
    idle(3);
    frame_len = 30;
    base = launches;
    for (int i = 0; i < 6; i++) write_byte(8'h60 + 8'(i));
    end_writes();
    idle(2);
    check_eq("pre_rst_count", o_Count, 5);
    pulse_reset();
    check_eq("mid_rst_count", o_Count, 0);
    check_eq("mid_rst_empty", o_Empty, 1);
    check_eq("mid_rst_dv", o_Tx_DV, 0);
    idle(60);
    check_eq("mid_rst_launches", launches - base, 1);
    frame_len = 10;
    write_byte(8'h5A);
    end_writes();
    wait_drain("post_rst_drain", 200);
    check_eq("post_rst_launches", launches - base, 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer that sits directly upstream of the UART transmitter.
- Accepts bytes from the host side in bursts, one per clock.
- Hands the bytes to the transmitter one at a time using its data-valid / active / done interface, so a burst goes out back-to-back on the serial line.
- Adds a watchdog so a transmitter that never signals done cannot hang the queue.

Parameters:
- DEPTH, 16, FIFO entries; must be a power of two, at least 2.
- ADDR_W, 4, equals log2(DEPTH).
- FREQUENCY, 87, clocks per serial bit; same value as the transmitter it feeds.
- GAP_CYCLES, 2, idle clocks after each transmitter done before the next launch; range 1..255.

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_Wr_En  in  1  write strobe for a host byte.
- i_Wr_Byte  in  8  host byte to queue.
- o_Full  out  1  FIFO holds DEPTH entries.
- o_Empty  out  1  FIFO holds 0 entries.
- o_Count  out  ADDR_W+1  current occupancy, 0..DEPTH.
- o_Overflow  out  1  one-cycle pulse when a write is dropped.
- o_Tx_DV  out  1  data-valid to the transmitter's i_DV.
- o_Tx_Byte  out  8  byte to the transmitter's i_Byte.
- i_Tx_Active  in  1  from the transmitter's o_Sig_Active.
- i_Tx_Done  in  1  from the transmitter's o_Sig_Done.
- o_Busy  out  1  high when the FSM is not in IDLE or the FIFO is not empty.
- o_Timeout  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high. All outputs are registered.
- Reset values:
  - o_Empty=1, o_Full=0, o_Count=0.
  - o_Overflow=0, o_Tx_DV=0, o_Tx_Byte=8'h00, o_Busy=0, o_Timeout=0.
  - Read and write pointers are 0. FSM is in IDLE.
- Reset mid-operation: FIFO contents are discarded. The transmitter may still be finishing a frame; it is protected by the i_Tx_Active check in IDLE.
- Write:
  - Accepted when i_Wr_En=1 and the registered o_Full=0.
  - Data is stored at the write pointer. The pointer wraps modulo DEPTH.
- Write while full:
  - The byte is dropped and o_Overflow pulses high for 1 cycle.
  - This applies even if a pop happens in the same cycle: the full check uses the registered o_Full.
- Simultaneous accepted write and pop: o_Count is unchanged and both pointers advance.
- FSM states and transitions:
  - IDLE: if o_Empty=0 and i_Tx_Active=0, then on the next edge:
    - o_Tx_DV<=1;
    - o_Tx_Byte<=head entry;
    - read pointer advances and o_Count decrements;
    - FSM goes to SEND.
  - SEND:
    - o_Tx_DV<=0, so it is high for exactly 1 cycle.
    - o_Tx_Byte holds its value.
    - A watchdog counter counts up from 0.
    - On i_Tx_Done=1, go to GAP.
    - If the counter reaches 12*FREQUENCY-1 first, pulse o_Timeout for 1 cycle and go to GAP.
  - GAP: count GAP_CYCLES clocks, then go to IDLE.
- Launch latency: if a write lands in an empty FIFO with FSM in IDLE and transmitter idle, o_Tx_DV is high in the cycle immediately after the first cycle in which o_Empty=0.
- Ordering: bytes leave in strict write order. Overflow drops never reorder the queue.
- Done outside SEND: an i_Tx_Done seen in IDLE or GAP is ignored.
- o_Count always equals the number of writes accepted minus the number of launches, never more than DEPTH.

Test Plan:
- Reset, then a single write of 8'hA5 → o_Tx_DV is high for exactly 1 cycle with o_Tx_Byte=8'hA5. With the real transmitter attached, the receiver reports o_DV and o_Byte=8'hA5.
- Burst of 4 writes (8'h01..8'h04) on consecutive cycles → o_Count peaks at 3.
  - Four launches occur in order 01,02,03,04.
  - Each launch comes GAP_CYCLES+1 cycles after the preceding i_Tx_Done.
  - o_Busy falls after the 4th done plus the gap.
- 17 writes into DEPTH=16 with the transmitter held active (i_Tx_Active=1) → o_Full=1 and o_Count=16.
  - The 17th write produces a 1-cycle o_Overflow pulse and no count change.
  - After release, 16 bytes drain in order.
- Full FIFO with a write in the same cycle as a launch → the write is dropped (o_Overflow pulses) and o_Count becomes 15.
- Stub transmitter that never asserts i_Tx_Done → o_Timeout pulses 1044 cycles after o_Tx_DV (FREQUENCY=87). The FSM passes through GAP and launches the next queued byte.
- Assert rst for 1 cycle during SEND with 5 bytes queued → next cycle o_Count=0, o_Empty=1, o_Tx_DV=0. No further launches until a new write.
